// File: rtl/uart_fifo_core.sv
// UART with TX/RX FIFOs, programmable baud divider, 16x-oversampled receiver and
// a byte-wide Wishbone-style register slave.
module uart_fifo_core #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_RESET  = 6
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tx_bit,
  input  logic       rx_bit,
  input  logic [2:0] wb_addr,
  input  logic [7:0] wb_data_in,
  output logic [7:0] wb_data_out,
  input  logic       wb_we,
  input  logic       wb_stb,
  output logic       wb_ack,
  output logic       irq
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  LastBit = 3'(DATA_BITS - 1);
  localparam logic [AW:0] PtrOne  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop1, TxStop2} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic                 tx_full, tx_empty, rx_full, rx_empty;
  logic                 tx_push, tx_pop, rx_push_ok, rx_pop, stat_rd;
  logic [DATA_BITS-1:0] tx_head, rx_head;

  logic       bus_acc, bus_wr, bus_rd;
  logic [4:0] ctrl_q;
  logic [7:0] status, rd_data;
  logic       ovr_q, ferr_q, perr_q;

  logic [15:0] div_q, baud_cnt_q;
  logic [3:0]  tick_cnt_q;
  logic        tick16, bit_tick;

  tx_state_e            tx_state_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic [2:0]           tx_cnt_q;
  logic                 tx_par_q, tx_par_en_q, tx_two_stop_q;

  rx_state_e            rx_state_q;
  logic                 rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
  logic [3:0]           rx_samp_q;
  logic [2:0]           rx_cnt_q;
  logic [DATA_BITS-1:0] rx_sh_q, rx_push_data_q;
  logic                 rx_par_en_q, rx_par_odd_q, rx_par_bit_q, rx_done_q;
  logic                 rx_push_q, rx_ferr_q, rx_perr_q;

  // Bus decode: a new cycle is accepted only while ack is low.
  assign bus_acc = wb_stb & ~wb_ack;
  assign bus_wr  = bus_acc & wb_we;
  assign bus_rd  = bus_acc & ~wb_we;
  assign stat_rd = bus_rd & (wb_addr == 3'd5);

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];
  assign rx_head  = rx_mem[rx_rd_q[AW-1:0]];

  assign tx_push    = bus_wr & (wb_addr == 3'd0) & ~tx_full;
  assign rx_pop     = bus_rd & (wb_addr == 3'd1) & ~rx_empty;
  assign rx_push_ok = rx_push_q & (~rx_full | rx_pop);
  assign tx_pop     = bit_tick & ~tx_empty &
                      ((tx_state_q == TxIdle) || (tx_state_q == TxStop2) ||
                       ((tx_state_q == TxStop1) && !tx_two_stop_q));

  always_ff @(posedge clk) begin
    if (tx_push)    tx_mem[tx_wr_q[AW-1:0]] <= wb_data_in[DATA_BITS-1:0];
    if (rx_push_ok) rx_mem[rx_wr_q[AW-1:0]] <= rx_push_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      if (tx_push)    tx_wr_q <= tx_wr_q + PtrOne;
      if (tx_pop)     tx_rd_q <= tx_rd_q + PtrOne;
      if (rx_push_ok) rx_wr_q <= rx_wr_q + PtrOne;
      if (rx_pop)     rx_rd_q <= rx_rd_q + PtrOne;
    end
  end

  assign tick16   = (baud_cnt_q == div_q);
  assign bit_tick = tick16 & (tick_cnt_q == 4'hf);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= 16'(DIV_RESET);
      baud_cnt_q <= '0;
      tick_cnt_q <= '0;
    end else begin
      if (bus_wr && wb_addr == 3'd2) div_q[7:0]  <= wb_data_in;
      if (bus_wr && wb_addr == 3'd3) div_q[15:8] <= wb_data_in;
      if (bus_wr && (wb_addr == 3'd2 || wb_addr == 3'd3)) baud_cnt_q <= '0;
      else if (tick16)                                    baud_cnt_q <= '0;
      else                                                baud_cnt_q <= baud_cnt_q + 16'd1;
      if (tick16) tick_cnt_q <= tick_cnt_q + 4'd1;
    end
  end

  // Frame settings are latched at the pop so a CTRL write never alters a frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q    <= TxIdle;
      tx_bit        <= 1'b1;
      tx_sh_q       <= '0;
      tx_cnt_q      <= '0;
      tx_par_q      <= 1'b0;
      tx_par_en_q   <= 1'b0;
      tx_two_stop_q <= 1'b0;
    end else if (tx_pop) begin
      tx_state_q    <= TxStart;
      tx_bit        <= 1'b0;
      tx_sh_q       <= tx_head;
      tx_par_q      <= ^tx_head ^ ctrl_q[1];
      tx_par_en_q   <= ctrl_q[0];
      tx_two_stop_q <= ctrl_q[2];
    end else if (bit_tick) begin
      unique case (tx_state_q)
        TxStart: begin
          tx_bit     <= tx_sh_q[0];
          tx_sh_q    <= tx_sh_q >> 1;
          tx_cnt_q   <= '0;
          tx_state_q <= TxData;
        end
        TxData: begin
          if (tx_cnt_q == LastBit) begin
            tx_bit     <= tx_par_en_q ? tx_par_q : 1'b1;
            tx_state_q <= tx_par_en_q ? TxParity : TxStop1;
          end else begin
            tx_bit   <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
            tx_cnt_q <= tx_cnt_q + 3'd1;
          end
        end
        TxParity: begin
          tx_bit     <= 1'b1;
          tx_state_q <= TxStop1;
        end
        TxStop1: tx_state_q <= tx_two_stop_q ? TxStop2 : TxIdle;
        TxStop2: tx_state_q <= TxIdle;
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign rx_fall = rx_s3_q & ~rx_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q        <= 1'b1;
      rx_s2_q        <= 1'b1;
      rx_s3_q        <= 1'b1;
      rx_state_q     <= RxIdle;
      rx_samp_q      <= '0;
      rx_cnt_q       <= '0;
      rx_sh_q        <= '0;
      rx_par_en_q    <= 1'b0;
      rx_par_odd_q   <= 1'b0;
      rx_par_bit_q   <= 1'b0;
      rx_done_q      <= 1'b0;
      rx_push_q      <= 1'b0;
      rx_push_data_q <= '0;
      rx_ferr_q      <= 1'b0;
      rx_perr_q      <= 1'b0;
    end else begin
      rx_s1_q   <= rx_bit;
      rx_s2_q   <= rx_s1_q;
      rx_s3_q   <= rx_s2_q;
      rx_push_q <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          rx_done_q <= 1'b0;
          if (rx_fall) begin
            rx_state_q   <= RxStart;
            rx_samp_q    <= '0;
            rx_par_en_q  <= ctrl_q[0];
            rx_par_odd_q <= ctrl_q[1];
          end
        end
        RxStart: if (tick16) begin
          if (rx_samp_q == 4'd7) begin
            rx_state_q <= rx_s2_q ? RxIdle : RxData;
            rx_samp_q  <= '0;
            rx_cnt_q   <= '0;
          end else rx_samp_q <= rx_samp_q + 4'd1;
        end
        RxData: if (tick16) begin
          if (rx_samp_q == 4'hf) begin
            rx_samp_q <= '0;
            rx_sh_q   <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            rx_cnt_q  <= rx_cnt_q + 3'd1;
            if (rx_cnt_q == LastBit) rx_state_q <= rx_par_en_q ? RxParity : RxStop;
          end else rx_samp_q <= rx_samp_q + 4'd1;
        end
        RxParity: if (tick16) begin
          if (rx_samp_q == 4'hf) begin
            rx_samp_q    <= '0;
            rx_par_bit_q <= rx_s2_q;
            rx_state_q   <= RxStop;
          end else rx_samp_q <= rx_samp_q + 4'd1;
        end
        RxStop: begin
          // After the stop sample, hold here until the line is high so a break is one frame.
          if (rx_done_q) begin
            if (rx_s2_q) rx_state_q <= RxIdle;
          end else if (tick16) begin
            if (rx_samp_q == 4'hf) begin
              rx_done_q      <= 1'b1;
              rx_push_q      <= 1'b1;
              rx_push_data_q <= rx_sh_q;
              rx_ferr_q      <= ~rx_s2_q;
              rx_perr_q      <= rx_par_en_q & (rx_par_bit_q != (^rx_sh_q ^ rx_par_odd_q));
            end else rx_samp_q <= rx_samp_q + 4'd1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  assign status = {(tx_state_q != TxIdle), perr_q, ferr_q, ovr_q,
                   rx_full, rx_empty, tx_empty, tx_full};

  always_comb begin
    rd_data = 8'h00;
    unique case (wb_addr)
      3'd1:    rd_data = rx_empty ? 8'h00 : 8'(rx_head);
      3'd2:    rd_data = div_q[7:0];
      3'd3:    rd_data = div_q[15:8];
      3'd4:    rd_data = {3'b000, ctrl_q};
      3'd5:    rd_data = status;
      default: rd_data = 8'h00;
    endcase
  end

  // Sticky flags: a set in the same cycle as the clearing STATUS read wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (stat_rd) begin
        ovr_q  <= 1'b0;
        ferr_q <= 1'b0;
        perr_q <= 1'b0;
      end
      if (rx_push_q && rx_full && !rx_pop) ovr_q  <= 1'b1;
      if (rx_push_q && rx_ferr_q)          ferr_q <= 1'b1;
      if (rx_push_q && rx_perr_q)          perr_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack      <= 1'b0;
      wb_data_out <= 8'h00;
      ctrl_q      <= '0;
      irq         <= 1'b0;
    end else begin
      wb_ack <= wb_stb;
      if (bus_acc)      wb_data_out <= wb_we ? 8'h00 : rd_data;
      else if (!wb_stb) wb_data_out <= 8'h00;
      if (bus_wr && wb_addr == 3'd4) ctrl_q <= wb_data_in[4:0];
      irq <= (ctrl_q[3] & ~rx_empty) | (ctrl_q[4] & tx_empty);
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: register access, TX waveforms, loopback RX,
// error flags, overrun and reset in mid-frame.
module tb_uart_fifo_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_bit, rx_bit;
  logic [2:0] wb_addr = '0;
  logic [7:0] wb_data_in = '0;
  logic [7:0] wb_data_out;
  logic       wb_we = 1'b0;
  logic       wb_stb = 1'b0;
  logic       wb_ack, irq;
  logic       loop_en = 1'b0;
  logic       rx_drv = 1'b1;

  int checks = 0;
  int errors = 0;

  assign rx_bit = loop_en ? tx_bit : rx_drv;

  always #5 clk = ~clk;

  uart_fifo_core #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_RESET(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_bit     (tx_bit),
    .rx_bit     (rx_bit),
    .wb_addr    (wb_addr),
    .wb_data_in (wb_data_in),
    .wb_data_out(wb_data_out),
    .wb_we      (wb_we),
    .wb_stb     (wb_stb),
    .wb_ack     (wb_ack),
    .irq        (irq)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    wb_addr = a; wb_data_in = d; wb_we = 1'b1; wb_stb = 1'b1;
    @(negedge clk);
    while (!wb_ack && n < 8) begin @(negedge clk); n++; end
    checks++;
    if (wb_ack !== 1'b1) begin
      errors++;
      $display("FAIL write_ack addr %0d: ack %b, required 1", a, wb_ack);
    end
    wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    int n = 0;
    @(negedge clk);
    wb_addr = a; wb_we = 1'b0; wb_stb = 1'b1;
    @(negedge clk);
    while (!wb_ack && n < 8) begin @(negedge clk); n++; end
    checks++;
    if (wb_ack !== 1'b1) begin
      errors++;
      $display("FAIL read_ack addr %0d: ack %b, required 1", a, wb_ack);
    end
    d = wb_data_out;
    wb_stb = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for the start bit, then records the line once per clock.
  task automatic capture_wave(input int ncyc, output logic [255:0] w, output bit found);
    int n = 0;
    w = '0;
    while (tx_bit !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    found = (tx_bit === 1'b0);
    if (found) begin
      for (int i = 0; i < ncyc; i++) begin w[i] = tx_bit; @(negedge clk); end
    end
  endtask

  task automatic drive_rx_frame(input logic [15:0] bits, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      rx_drv = bits[k];
      repeat (16) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_bit, wb_ack, wb_data_out, irq} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: tx %b ack %b dout %h irq %b, required 1 0 00 0",
               tx_bit, wb_ack, wb_data_out, irq);
    end
    reset = 1'b0;
    bus_read(3'd5, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL reset_status: %h, required 06", d); end
    bus_read(3'd2, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL reset_div_lo: %h, required 06", d); end
    bus_read(3'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_div_hi: %h, required 00", d); end
    bus_read(3'd4, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl: %h, required 00", d); end
  endtask

  task automatic test_regs;
    logic [7:0] d;
    bus_read(3'd6, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_read: %h, required 00", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rx_empty_read: %h, required 00", d); end
    bus_write(3'd2, 8'h34);
    bus_write(3'd3, 8'h12);
    bus_read(3'd2, d);
    checks++; if (d !== 8'h34) begin errors++; $display("FAIL div_lo_rb: %h, required 34", d); end
    bus_read(3'd3, d);
    checks++; if (d !== 8'h12) begin errors++; $display("FAIL div_hi_rb: %h, required 12", d); end
    bus_write(3'd2, 8'h00);
    bus_write(3'd3, 8'h00);
  endtask

  task automatic test_handshake;
    @(negedge clk);
    wb_addr = 3'd5; wb_we = 1'b0; wb_stb = 1'b1;
    @(negedge clk);
    checks++;
    if ({wb_ack, wb_data_out} !== {1'b1, 8'h06}) begin
      errors++; $display("FAIL read_latency: ack %b data %h, required 1 06", wb_ack, wb_data_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wb_ack !== 1'b1) begin errors++; $display("FAIL ack_held: %b, required 1", wb_ack); end
    wb_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_ack !== 1'b0) begin errors++; $display("FAIL ack_drop: %b, required 0", wb_ack); end
  endtask

  task automatic test_irq;
    bus_write(3'd4, 8'h10);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty: %b, required 1", irq); end
    bus_write(3'd4, 8'h08);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_rx_empty: %b, required 0", irq); end
    bus_write(3'd4, 8'h00);
  endtask

  task automatic test_tx_basic;
    logic [255:0] w;
    logic [9:0]   got;
    logic [7:0]   d;
    bit           found;
    bus_write(3'd0, 8'h55);
    capture_wave(176, w, found);
    checks++; if (!found) begin errors++; $display("FAIL tx_basic_start: no start bit seen"); end
    for (int k = 0; k < 10; k++) got[k] = w[8 + 16 * k];
    checks++;
    if (got !== {1'b1, 8'h55, 1'b0}) begin
      errors++; $display("FAIL tx_basic_frame: %b, required %b", got, {1'b1, 8'h55, 1'b0});
    end
    checks++;
    if ({w[15], w[16]} !== 2'b01) begin
      errors++; $display("FAIL tx_start_width: w15 %b w16 %b, required 0 1", w[15], w[16]);
    end
    bus_read(3'd5, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL tx_basic_status: %h, required 06", d); end
  endtask

  task automatic test_tx_parity;
    logic [255:0] w;
    logic [11:0]  got;
    logic [10:0]  got_odd;
    logic         high_ok;
    bit           found;
    bus_write(3'd4, 8'h05);
    bus_write(3'd0, 8'h07);
    capture_wave(200, w, found);
    checks++; if (!found) begin errors++; $display("FAIL tx_par_start: no start bit seen"); end
    for (int k = 0; k < 12; k++) got[k] = w[8 + 16 * k];
    checks++;
    if (got !== {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}) begin
      errors++; $display("FAIL tx_par_even: %b, required %b", got, {3'b111, 8'h07, 1'b0});
    end
    high_ok = 1'b1;
    for (int i = 160; i < 192; i++) high_ok &= w[i];
    checks++;
    if (high_ok !== 1'b1) begin errors++; $display("FAIL tx_two_stop: line not high 32 clk"); end
    bus_write(3'd4, 8'h03);
    bus_write(3'd0, 8'h07);
    capture_wave(184, w, found);
    for (int k = 0; k < 11; k++) got_odd[k] = w[8 + 16 * k];
    checks++;
    if (got_odd !== {1'b1, 1'b0, 8'h07, 1'b0}) begin
      errors++; $display("FAIL tx_par_odd: %b, required %b", got_odd, {2'b10, 8'h07, 1'b0});
    end
    bus_write(3'd4, 8'h00);
  endtask

  task automatic test_loopback;
    logic [7:0] d;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hA3; exp_b[1] = 8'h00; exp_b[2] = 8'hFF;
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) bus_write(3'd0, exp_b[i]);
    repeat (40) @(negedge clk);
    bus_read(3'd5, d);
    checks++; if (d !== 8'h84) begin errors++; $display("FAIL loop_busy_status: %h, required 84", d); end
    repeat (600) @(negedge clk);
    bus_read(3'd5, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL loop_rx_status: %h, required 02", d); end
    for (int i = 0; i < 3; i++) begin
      bus_read(3'd1, d);
      checks++;
      if (d !== exp_b[i]) begin
        errors++; $display("FAIL loop_rx_byte%0d: %h, required %h", i, d, exp_b[i]);
      end
    end
    bus_read(3'd5, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL loop_end_status: %h, required 06", d); end
    loop_en = 1'b0;
  endtask

  task automatic test_rx_errors;
    logic [7:0] d;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    bus_read(3'd5, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL rx_glitch: status %h, required 06", d); end
    drive_rx_frame({6'b0, 1'b0, 8'h3C, 1'b0}, 10);
    repeat (40) @(negedge clk);
    bus_read(3'd5, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL frame_err_set: %h, required 22", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL frame_err_byte: %h, required 3c", d); end
    bus_read(3'd5, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL frame_err_clear: %h, required 06", d); end
    bus_write(3'd4, 8'h01);
    drive_rx_frame({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (40) @(negedge clk);
    bus_read(3'd5, d);
    checks++; if (d !== 8'h42) begin errors++; $display("FAIL par_err_set: %h, required 42", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 8'h07) begin errors++; $display("FAIL par_err_byte: %h, required 07", d); end
    bus_write(3'd4, 8'h00);
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    loop_en = 1'b1;
    for (int i = 0; i < 17; i++) bus_write(3'd0, 8'(i * 37 + 1));
    repeat (3000) @(negedge clk);
    bus_read(3'd5, d);
    checks++; if (d !== 8'h1A) begin errors++; $display("FAIL overrun_status: %h, required 1a", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(3'd1, d);
      checks++;
      if (d !== 8'(i * 37 + 1)) begin
        errors++; $display("FAIL overrun_byte%0d: %h, required %h", i, d, 8'(i * 37 + 1));
      end
    end
    bus_read(3'd5, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL overrun_clear: %h, required 06", d); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    int n = 0;
    bus_write(3'd0, 8'hF0);
    while (tx_bit !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    repeat (72) @(negedge clk);
    checks++;
    if (tx_bit !== 1'b0) begin errors++; $display("FAIL mid_bit3: tx %b, required 0", tx_bit); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_bit !== 1'b1) begin errors++; $display("FAIL reset_tx_idle: tx %b, required 1", tx_bit); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(3'd5, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL mid_reset_status: %h, required 06", d); end
    bus_read(3'd2, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL mid_reset_div: %h, required 06", d); end
    repeat (300) @(negedge clk);
    bus_read(3'd5, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL mid_reset_no_rx: %h, required 06", d); end
    loop_en = 1'b0;
  endtask

  initial begin
    test_reset;
    test_regs;
    test_handshake;
    test_irq;
    test_tx_basic;
    test_tx_parity;
    test_loopback;
    test_rx_errors;
    test_overrun;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
